mem_port_arbiter: RTL and testbench

Sequences and shares the single memory port between the CPU's instruction-fetch requester and its data load/store requester. It replaces the combinational `pc_en ? pc : l_addr` read-address select with a registered, handshaked arbiter. It sits between `cpu` and `dbg_mem` in the multicycle top and performs one memory access per transaction. Data accesses have priority, and a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data requesters.
// Three-state FSM (IDLE/ISSUE/RESP); data has priority, a starvation counter forces fetch progress.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int W            = `WORD_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [W-1:0] i_addr,
  output logic         i_ack,
  output logic [W-1:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic         d_ack,
  output logic [W-1:0] d_rdata,
  output logic         mem_read_en,
  output logic [W-1:0] mem_read_addr,
  input  logic [W-1:0] mem_read_data,
  output logic         mem_write_en,
  output logic [W-1:0] mem_write_addr,
  output logic [W-1:0] mem_write_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, nxt;
  logic             gnt_i, gnt_d;
  logic             own_i, we_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [W-1:0]     i_rdata_q, d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    case (state)
      IDLE: begin
        // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row.
        gnt_d = d_req && !(i_req && starve_cnt == LIMIT);
        gnt_i = i_req && !gnt_d;
        if (gnt_d || gnt_i) nxt = ISSUE;
      end
      ISSUE:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt     <= '0;
      own_i          <= 1'b0;
      we_q           <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      if (state == IDLE) begin
        if (gnt_i || !i_req)               starve_cnt <= '0;
        else if (gnt_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end
      if (gnt_i) begin
        own_i         <= 1'b1;
        we_q          <= 1'b0;
        mem_read_addr <= i_addr;
      end else if (gnt_d) begin
        own_i <= 1'b0;
        we_q  <= d_we;
        if (d_we) begin
          mem_write_addr <= d_addr;
          mem_write_data <= d_wdata;
        end else begin
          mem_read_addr <= d_addr;
        end
      end
      if (i_ack)          i_rdata_q <= mem_read_data;
      if (d_ack && !we_q) d_rdata_q <= mem_read_data;
    end
  end

  assign busy         = (state != IDLE);
  assign mem_read_en  = (state == ISSUE) && !we_q;
  assign mem_write_en = (state == ISSUE) && we_q;
  assign i_ack        = (state == RESP) && own_i;
  assign d_ack        = (state == RESP) && !own_i;
  // Read data is forwarded during the ack cycle and held in the register afterwards.
  assign i_rdata      = i_ack ? mem_read_data : i_rdata_q;
  assign d_rdata      = (d_ack && !we_q) ? mem_read_data : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, busy;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .busy(busy)
  );

  // Read data appears the cycle after the enable; writes land on the negedge of ISSUE.
  always @(posedge clk) if (mem_read_en) mem_read_data <= mem[mem_read_addr[9:2]];
  always @(negedge clk) begin
    if (mem_write_en) mem[mem_write_addr[9:2]] <= mem_write_data;
    else if (pre_we)  mem[pre_idx] <= pre_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    int nd, ni, nd_iss, last;
    logic [6:0] ord;
    mem_read_data = '0;
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b1; pre_idx = 8'd16; pre_data = 32'h2402000A;
    step; step;
    pre_we = 1'b0;
    chk("rst_busy",   32'(busy), 0);
    chk("rst_iack",   32'(i_ack), 0);
    chk("rst_dack",   32'(d_ack), 0);
    chk("rst_ren",    32'(mem_read_en), 0);
    chk("rst_wen",    32'(mem_write_en), 0);
    chk("rst_raddr",  mem_read_addr, 0);
    chk("rst_waddr",  mem_write_addr, 0);
    chk("rst_wdata",  mem_write_data, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    rst = 1'b0;
    step;

    // Lone fetch
    i_req = 1; i_addr = 32'h40;
    step;
    chk("f_ren",   32'(mem_read_en), 1);
    chk("f_raddr", mem_read_addr, 32'h40);
    chk("f_wen",   32'(mem_write_en), 0);
    chk("f_busy",  32'(busy), 1);
    step;
    chk("f_iack",  32'(i_ack), 1);
    chk("f_rdata", i_rdata, 32'h2402000A);
    chk("f_dack",  32'(d_ack), 0);
    i_req = 0;
    step;
    chk("f_idle",  32'(busy), 0);
    chk("f_iack0", 32'(i_ack), 0);
    chk("f_hold",  i_rdata, 32'h2402000A);

    // Store then load
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    step;
    chk("s_wen",   32'(mem_write_en), 1);
    chk("s_ren",   32'(mem_read_en), 0);
    chk("s_waddr", mem_write_addr, 32'h100);
    chk("s_wdata", mem_write_data, 32'hDEADBEEF);
    step;
    chk("s_dack",  32'(d_ack), 1);
    chk("s_drd",   d_rdata, 0);
    chk("s_iack",  32'(i_ack), 0);
    d_req = 0;
    step;
    chk("s_mem",   mem[64], 32'hDEADBEEF);
    d_req = 1; d_we = 0;
    step;
    chk("l_ren",   32'(mem_read_en), 1);
    chk("l_raddr", mem_read_addr, 32'h100);
    step;
    chk("l_dack",  32'(d_ack), 1);
    chk("l_drd",   d_rdata, 32'hDEADBEEF);
    chk("l_ird",   i_rdata, 32'h2402000A);
    d_req = 0;
    step;

    // Simultaneous requests: 6 loads against a held fetch
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
    nd = 0; ni = 0; nd_iss = 0; ord = '0;
    for (int c = 0; c < 40 && !(nd == 6 && ni == 1); c++) begin
      step;
      if (mem_read_en && mem_read_addr == 32'h100) begin
        nd_iss++;
        if (nd_iss == 4) chk("sv_cnt4", 32'(dut.starve_cnt), 4);
      end
      if (mem_read_en && mem_read_addr == 32'h40) chk("sv_cnt0", 32'(dut.starve_cnt), 0);
      if (d_ack) begin
        nd++; ord = {ord[5:0], 1'b0};
        if (nd == 6) d_req = 0;
      end
      if (i_ack) begin
        ni++; ord = {ord[5:0], 1'b1};
        chk("sv_ird", i_rdata, 32'h2402000A);
        i_req = 0;
      end
    end
    chk("sv_nd",  32'(nd), 6);
    chk("sv_ni",  32'(ni), 1);
    chk("sv_ord", 32'(ord), 32'b0000100);
    step;

    // Lone data requests
    d_req = 1; d_we = 0; d_addr = 32'h100;
    nd = 0; ni = 0; last = 0;
    for (int c = 0; c < 30 && nd < 5; c++) begin
      step;
      if (i_ack) ni++;
      if (d_ack) begin
        chk("ld_cnt", 32'(dut.starve_cnt), 0);
        if (nd > 0) chk("ld_gap", 32'(cyc - last), 3);
        last = cyc;
        nd++;
        if (nd == 5) d_req = 0;
      end
    end
    chk("ld_nd", 32'(nd), 5);
    chk("ld_ni", 32'(ni), 0);
    step;

    // Reset during ISSUE of a load
    d_req = 1; d_we = 0; d_addr = 32'h100;
    step;
    chk("r_ren", 32'(mem_read_en), 1);
    rst = 1;
    step;
    rst = 0;
    chk("r_dack",  32'(d_ack), 0);
    chk("r_busy",  32'(busy), 0);
    chk("r_ren0",  32'(mem_read_en), 0);
    chk("r_raddr", mem_read_addr, 0);
    chk("r_drd",   d_rdata, 0);
    chk("r_ird",   i_rdata, 0);
    step;
    chk("r2_ren",  32'(mem_read_en), 1);
    step;
    chk("r2_dack", 32'(d_ack), 1);
    chk("r2_drd",  d_rdata, 32'hDEADBEEF);
    d_req = 0;
    step;

    // Fetch request held through its ack cycle
    i_req = 1; i_addr = 32'h40;
    step;
    chk("h_ren1",  32'(mem_read_en), 1);
    step;
    chk("h_ack1",  32'(i_ack), 1);
    step;
    chk("h_ack0",  32'(i_ack), 0);
    chk("h_idle",  32'(busy), 0);
    step;
    chk("h_ren2",  32'(mem_read_en), 1);
    chk("h_ack0b", 32'(i_ack), 0);
    step;
    chk("h_ack2",  32'(i_ack), 1);
    i_req = 0;
    step;
    chk("h_ack0c", 32'(i_ack), 0);
    step;
    chk("h_end",   32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
